// File: rtl/cpu_clk_sched.sv
// CPU advance scheduler: issues a one-cycle clock enable to the core every div+1
// clk cycles, with run / halt / N-step control, stall hold-off and a pulse counter.
module cpu_clk_sched #(
   parameter int unsigned DIV_WIDTH   = 5,
   parameter int unsigned DEFAULT_DIV = 31,
   parameter int unsigned STEP_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [STEP_WIDTH-1:0] cmd_arg,
   input  logic                  stall,
   output logic                  cpu_ce,
   output logic                  running,
   output logic                  step_done,
   output logic [31:0]           ce_count
);

   localparam logic [1:0] OP_SET_DIV = 2'b00;
   localparam logic [1:0] OP_RUN     = 2'b01;
   localparam logic [1:0] OP_HALT    = 2'b10;
   localparam logic [1:0] OP_STEP    = 2'b11;

   typedef enum logic [1:0] {
      HALTED   = 2'b00,
      RUNNING  = 2'b01,
      STEPPING = 2'b10
   } state_t;

   state_t                  state, state_n;
   logic [DIV_WIDTH-1:0]    div, div_n;
   logic [DIV_WIDTH-1:0]    cnt, cnt_n;
   logic [STEP_WIDTH-1:0]   remaining, remaining_n;
   logic                    step_done_n;
   logic                    cmd_accept;
   logic                    step_zero;

   assign cmd_accept = cmd_valid && cmd_ready;
   assign step_zero  = (cmd_arg == '0);

   // Enable is combinational so a stall release or reset acts in the same cycle
   assign cpu_ce = (state != HALTED) && (cnt == div) && !stall && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HALTED;
         div       <= DIV_WIDTH'(DEFAULT_DIV);
         cnt       <= '0;
         remaining <= '0;
         step_done <= 1'b0;
         running   <= 1'b0;
         ce_count  <= '0;
         cmd_ready <= 1'b1;
      end else begin
         state     <= state_n;
         div       <= div_n;
         cnt       <= cnt_n;
         remaining <= remaining_n;
         step_done <= step_done_n;
         running   <= (state_n != HALTED);
         cmd_ready <= 1'b1;
         if (cpu_ce) begin
            ce_count <= ce_count + 32'd1;
         end
      end
   end

   always_comb begin
      state_n     = state;
      div_n       = div;
      cnt_n       = cnt;
      remaining_n = remaining;
      step_done_n = 1'b0;

      // Divide counter; a due tick is held pending while stalled
      if (state != HALTED) begin
         if (cnt < div) begin
            cnt_n = cnt + DIV_WIDTH'(1);
         end else if (cpu_ce) begin
            cnt_n = '0;
         end
      end

      // Step accounting; the final step completes even if a command overrides the state
      if (state == STEPPING && cpu_ce) begin
         remaining_n = remaining - STEP_WIDTH'(1);
         if (remaining == STEP_WIDTH'(1)) begin
            state_n     = HALTED;
            step_done_n = 1'b1;
         end
      end

      if (cmd_accept) begin
         case (cmd_op)
            OP_SET_DIV: begin
               div_n = cmd_arg[DIV_WIDTH-1:0];
               cnt_n = '0;
            end
            OP_RUN: begin
               if (state == HALTED) begin
                  cnt_n = '0;
               end
               state_n = RUNNING;
            end
            OP_HALT: begin
               state_n = HALTED;
            end
            OP_STEP: begin
               if (step_zero) begin
                  state_n     = HALTED;
                  step_done_n = 1'b1;
               end else begin
                  if (state == HALTED) begin
                     cnt_n = '0;
                  end
                  state_n     = STEPPING;
                  remaining_n = cmd_arg;
               end
            end
            default: begin
               state_n = state;
            end
         endcase
      end

      // The counter rests at zero whenever the core is halted
      if (state_n == HALTED) begin
         cnt_n = '0;
      end
   end

endmodule

// File: tb/tb_cpu_clk_sched.sv
// Directed bench for cpu_clk_sched: run/step/halt sequencing, stall hold-off,
// command collision with the final step, and mid-run reset.
module tb_cpu_clk_sched;

   localparam logic [1:0] OP_SET_DIV = 2'b00;
   localparam logic [1:0] OP_RUN     = 2'b01;
   localparam logic [1:0] OP_HALT    = 2'b10;
   localparam logic [1:0] OP_STEP    = 2'b11;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic        stall;
   logic        cpu_ce;
   logic        running;
   logic        step_done;
   logic [31:0] ce_count;

   int checks = 0;
   int errors = 0;

   cpu_clk_sched dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_arg   (cmd_arg),
      .stall     (stall),
      .cpu_ce    (cpu_ce),
      .running   (running),
      .step_done (step_done),
      .ce_count  (ce_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Offer one command for one cycle; returns in cycle 1 after acceptance
   task automatic send(input logic [1:0] op, input logic [15:0] arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      step_clk();
      cmd_valid = 1'b0;
      cmd_op    = OP_SET_DIV;
      cmd_arg   = '0;
   endtask

   // Count enables over n cycles, cycle index 1 being the current cycle
   task automatic count_ce(input int n, output int c, output int first, output int last);
      c = 0; first = 0; last = 0;
      for (int i = 1; i <= n; i++) begin
         if (cpu_ce) begin
            c++;
            if (first == 0) first = i;
            last = i;
         end
         step_clk();
      end
   endtask

   initial begin
      int c, first, last;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = OP_SET_DIV;
      cmd_arg   = '0;
      stall     = 1'b0;
      step_clk();
      step_clk();

      chk("rst_cpu_ce",    32'(cpu_ce),    32'd0);
      chk("rst_running",   32'(running),   32'd0);
      chk("rst_step_done", 32'(step_done), 32'd0);
      chk("rst_ce_count",  ce_count,       32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      reset = 1'b0;
      step_clk();
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);

      // RUN at default divide 31: enables at cycles 32, 64, 96
      send(OP_RUN, 16'd0);
      chk("run_running", 32'(running), 32'd1);
      count_ce(96, c, first, last);
      chk("run_first_ce", 32'(first), 32'd32);
      chk("run_num_ce",   32'(c),     32'd3);
      chk("run_last_ce",  32'(last),  32'd96);
      chk("run_ce_count", ce_count,   32'd3);
      send(OP_HALT, 16'd0);
      chk("halt_running", 32'(running), 32'd0);
      count_ce(40, c, first, last);
      chk("halt_no_ce", 32'(c), 32'd0);

      // Divide 0, STEP 5: five back-to-back enables then step_done
      send(OP_SET_DIV, 16'd0);
      send(OP_STEP, 16'd5);
      chk("step5_running", 32'(running), 32'd1);
      count_ce(5, c, first, last);
      chk("step5_num_ce", 32'(c),     32'd5);
      chk("step5_first",  32'(first), 32'd1);
      chk("step5_done",    32'(step_done), 32'd1);
      chk("step5_no_ce",   32'(cpu_ce),    32'd0);
      chk("step5_halted",  32'(running),   32'd0);
      chk("step5_count",   ce_count,       32'd8);
      step_clk();
      chk("step5_done_one", 32'(step_done), 32'd0);

      // Divide 3, stall held 7 cycles over the due tick
      send(OP_SET_DIV, 16'd3);
      send(OP_RUN, 16'd0);
      count_ce(3, c, first, last);
      chk("stall_pre_ce", 32'(c), 32'd0);
      stall = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #1;
         chk("stall_hold", 32'(cpu_ce), 32'd0);
         step_clk();
      end
      stall = 1'b0;
      #1;
      chk("stall_release_ce", 32'(cpu_ce), 32'd1);
      step_clk();
      count_ce(4, c, first, last);
      chk("stall_next_first", 32'(first), 32'd4);
      chk("stall_next_num",   32'(c),     32'd1);
      chk("stall_count",      ce_count,   32'd10);
      send(OP_HALT, 16'd0);

      // Divide 2, STEP 1 with HALT colliding with the final enable
      send(OP_SET_DIV, 16'd2);
      send(OP_STEP, 16'd1);
      step_clk();
      step_clk();
      cmd_valid = 1'b1;
      cmd_op    = OP_HALT;
      #1;
      chk("collide_ce", 32'(cpu_ce), 32'd1);
      step_clk();
      cmd_valid = 1'b0;
      chk("collide_done",    32'(step_done), 32'd1);
      chk("collide_halted",  32'(running),   32'd0);
      chk("collide_count",   ce_count,       32'd11);
      step_clk();
      chk("collide_done_one", 32'(step_done), 32'd0);
      chk("collide_no_ce",    32'(cpu_ce),    32'd0);

      // Divide 1, reset for one cycle while an enable is due
      send(OP_SET_DIV, 16'd1);
      send(OP_RUN, 16'd0);
      step_clk();
      step_clk();
      step_clk();
      chk("pre_reset_ce", 32'(cpu_ce), 32'd1);
      reset = 1'b1;
      #1;
      chk("reset_ce_forced", 32'(cpu_ce), 32'd0);
      step_clk();
      reset = 1'b0;
      #1;
      chk("post_reset_running", 32'(running), 32'd0);
      chk("post_reset_count",   ce_count,     32'd0);
      count_ce(40, c, first, last);
      chk("post_reset_no_ce", 32'(c), 32'd0);
      send(OP_RUN, 16'd0);
      count_ce(32, c, first, last);
      chk("post_reset_div_first", 32'(first), 32'd32);
      chk("post_reset_div_num",   32'(c),     32'd1);

      // STEP 0 while running halts and pulses step_done once
      send(OP_STEP, 16'd0);
      chk("step0_halted", 32'(running),   32'd0);
      chk("step0_done",   32'(step_done), 32'd1);
      step_clk();
      chk("step0_done_one", 32'(step_done), 32'd0);
      count_ce(40, c, first, last);
      chk("step0_no_ce", 32'(c),   32'd0);
      chk("step0_count", ce_count, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
